ccd_exposure_seq: RTL
=====================

# ccd_exposure_seq

Phase sequencer for one CCD frame. It owns a single shared WIDTH-bit down-counter timer and reuses it for every timed phase: flush, exposure and vertical transfer. For each phase it loads the timer with that phase's length and waits for the timer's done flag. After the timed phases it requests a readout over a req/ack handshake, then reports frame completion. It sits between the host register block (lengths, start/abort) and the CCD clock-driver enables.

## Interface
- WIDTH, 16, width of phase lengths and timer preset
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  return to IDLE from any state; priority over start
- cont_mode  in  1  when high at DONE, begin next frame without a new start
- flush_len, exp_len, xfer_len  in  WIDTH each  phase lengths, latched at frame start
- timer_done  in  1  done flag from the shared timer
- rd_ack  in  1  readout engine accepts request
- timer_load  out  1  one-cycle load strobe to the timer
- timer_preset  out  WIDTH  preset value for the timer; valid while timer_load is high
- flush_en, shutter_open, xfer_en  out  1 each  phase enables to the CCD driver
- rd_req  out  1  readout request
- frame_done  out  1  one-cycle pulse per completed frame
- busy  out  1  high in every state except IDLE
- phase  out  3  0 idle, 1 flush, 2 expose, 3 transfer, 4 readout, 5 done

## Operation
- States: IDLE, FL_LD, FL_WT, EX_LD, EX_WT, XF_LD, XF_WT, READ, DONE.
- IDLE, start=1 and abort=0:
  - latch flush_len, exp_len and xfer_len into internal registers;
  - go to FL_LD.
- Every *_LD state:
  - timer_load=1 and timer_preset = the latched length for that phase;
  - timer_done is ignored;
  - next state is the matching *_WT.
- Every *_WT state: timer_load=0; advance only when timer_done=1.
  - FL_WT goes to EX_LD.
  - EX_WT goes to XF_LD.
  - XF_WT goes to READ.
- Phase enables are active in both the LD and WT states of their phase:
  - flush_en in FL_*;
  - shutter_open in EX_*;
  - xfer_en in XF_*.
- READ:
  - rd_req=1;
  - go to DONE on the first edge where rd_req=1 and rd_ack=1;
  - rd_req drops in the next cycle.
- DONE:
  - frame_done=1 for exactly one cycle;
  - if cont_mode=1, re-latch the three lengths and go to FL_LD;
  - otherwise go to IDLE.
- abort=1 in any state:
  - next state is IDLE;
  - no timer_load and no frame_done are issued;
  - all enables and rd_req are 0 from the next cycle.
- start while busy: ignored, with no queuing.
- Length inputs changed mid-frame: no effect until the next latch.
- Zero length is legal. The timer then asserts done immediately after load, and the phase takes its minimum duration.
- timer_preset is held at its last value outside the LD states.

## Timing
- Reset values:
  - state IDLE, phase 0;
  - all 1-bit outputs 0;
  - timer_preset 0 and latched lengths 0.
- Timer contract:
  - load high for one cycle holds count=preset through the following edge;
  - count then decrements each edge;
  - done is high from the edge after count reaches 0;
  - done clears asynchronously on load.
- Each timed phase lasts exactly len+3 cycles, measured from the first cycle of LD to the last cycle of WT:
  - 1 cycle in LD;
  - len+1 cycles of countdown;
  - 1 cycle for done to be sampled.
- start to flush_en: 1 cycle (start sampled at edge N; FL_LD from edge N).
- Phase enables switch on the same edge with no gap: flush_en falls on the same edge that shutter_open rises.
- READ lasts at least 1 cycle; rd_ack low holds READ indefinitely.
- Continuous mode: frame_done cycle is followed directly by FL_LD; inter-frame gap is 0 cycles.
- abort at the same edge as a WT-state timer_done: abort wins, and the next state is IDLE.
- rst asserted mid-frame clears all outputs immediately, without waiting for an edge.
- The timer is not reloaded by the sequencer until the next start.

## Test plan
- Basic frame, with the real timer connected:
  - stimulus: flush=2, exp=5, xfer=1, start pulse, rd_ack tied 1;
  - flush_en high 5 cycles, shutter_open 8, xfer_en 4;
  - rd_req high 1 cycle, then frame_done pulse;
  - busy high 19 cycles total.
- Zero lengths (all 0): each enable high exactly 3 cycles, and exactly one timer_load per phase, with presets 0, 0, 0.
- Readout backpressure: rd_ack held low 10 cycles, then high → rd_req high 11 cycles and phase=4 throughout, then frame_done.
- Abort in EX_WT (exp=100, abort at cycle 20 of exposure):
  - shutter_open falls the next cycle, phase=0;
  - no frame_done;
  - a new start runs a full frame normally.
- Continuous mode: cont_mode=1 for 3 frames, with lengths changed during frame 1 → frame_done pulses back-to-back per frame, and frame 2 uses the new lengths.
- Async reset asserted mid-FL_WT between clock edges → all outputs 0 immediately, and start after release runs a clean frame.

Source files
------------

// File: rtl/ccd_exposure_seq.sv
// ccd_exposure_seq: phase sequencer for one CCD frame.
//
// Steps through flush, exposure and vertical transfer using one shared external
// down-counter timer. Each timed phase loads the timer once (LD state) and then
// waits for its done flag (WT state). It then requests readout over rd_req/rd_ack
// and pulses frame_done. All outputs are registered: they are decoded from the
// next state, so each output changes on the same edge as the state.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   start, abort, cont_mode        host control (abort has priority)
//   flush_len, exp_len, xfer_len   phase lengths, latched at frame start
//   timer_done                     done flag from the shared timer
//   rd_ack                         readout engine accepts the request
//   timer_load, timer_preset       one-cycle load strobe and preset to the timer
//   flush_en, shutter_open, xfer_en  CCD driver phase enables
//   rd_req                         readout request
//   frame_done                     one-cycle pulse per completed frame
//   busy                           high in every state except idle
//   phase                          0 idle, 1 flush, 2 expose, 3 transfer, 4 readout, 5 done
module ccd_exposure_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [WIDTH-1:0] flush_len,
  input  logic [WIDTH-1:0] exp_len,
  input  logic [WIDTH-1:0] xfer_len,
  input  logic             timer_done,
  input  logic             rd_ack,
  output logic             timer_load,
  output logic [WIDTH-1:0] timer_preset,
  output logic             flush_en,
  output logic             shutter_open,
  output logic             xfer_en,
  output logic             rd_req,
  output logic             frame_done,
  output logic             busy,
  output logic [2:0]       phase
);

  typedef enum logic [3:0] {
    StIdle, StFlLd, StFlWt, StExLd, StExWt, StXfLd, StXfWt, StRead, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] flush_q, flush_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] xfer_q, xfer_d;
  logic             latch;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFlLd;
          latch   = 1'b1;
        end
      end
      StFlLd: state_d = StFlWt;
      StFlWt: if (timer_done) state_d = StExLd;
      StExLd: state_d = StExWt;
      StExWt: if (timer_done) state_d = StXfLd;
      StXfLd: state_d = StXfWt;
      StXfWt: if (timer_done) state_d = StRead;
      // rd_req is high for the whole of StRead, so rd_ack alone completes the handshake.
      StRead: if (rd_ack) state_d = StDone;
      StDone: begin
        if (cont_mode) begin
          state_d = StFlLd;
          latch   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      latch   = 1'b0;
    end
    flush_d = latch ? flush_len : flush_q;
    exp_d   = latch ? exp_len   : exp_q;
    xfer_d  = latch ? xfer_len  : xfer_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      flush_q      <= '0;
      exp_q        <= '0;
      xfer_q       <= '0;
      timer_load   <= 1'b0;
      timer_preset <= '0;
      flush_en     <= 1'b0;
      shutter_open <= 1'b0;
      xfer_en      <= 1'b0;
      rd_req       <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      phase        <= 3'd0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      exp_q        <= exp_d;
      xfer_q       <= xfer_d;
      timer_load   <= (state_d == StFlLd) || (state_d == StExLd) || (state_d == StXfLd);
      flush_en     <= (state_d == StFlLd) || (state_d == StFlWt);
      shutter_open <= (state_d == StExLd) || (state_d == StExWt);
      xfer_en      <= (state_d == StXfLd) || (state_d == StXfWt);
      rd_req       <= (state_d == StRead);
      frame_done   <= (state_d == StDone);
      busy         <= (state_d != StIdle);
      // Preset only moves when a load is issued; it holds otherwise.
      case (state_d)
        StFlLd:  timer_preset <= flush_d;
        StExLd:  timer_preset <= exp_d;
        StXfLd:  timer_preset <= xfer_d;
        default: timer_preset <= timer_preset;
      endcase
      case (state_d)
        StFlLd, StFlWt: phase <= 3'd1;
        StExLd, StExWt: phase <= 3'd2;
        StXfLd, StXfWt: phase <= 3'd3;
        StRead:         phase <= 3'd4;
        StDone:         phase <= 3'd5;
        default:        phase <= 3'd0;
      endcase
    end
  end

endmodule
